// File: rtl/shift_l_nbit_seq.sv
// Sequential logical left shifter: one barrel stage (shift by 2^i) per cycle,
// valid/ready handshake on both sides, sticky overflow on any 1-bit shifted out.
module shift_l_nbit_seq #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [SHIFT_WIDTH-1:0] B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       Y,
    output logic                   ovf
);

    localparam int CNT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHIFT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       stage_q, stage_d;
    logic [WIDTH-1:0]       data_q,  data_d;
    logic [SHIFT_WIDTH-1:0] amt_q,   amt_d;
    logic                   ovf_q,   ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            data_q  <= '0;
            amt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        data_d  = data_q;
        amt_d   = amt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = A;
                    amt_d   = B;
                    ovf_d   = 1'b0;
                    stage_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Each stage is a fixed shift by 2^i; stages at or beyond WIDTH flush everything.
                for (int unsigned i = 0; i < SHIFT_WIDTH; i++) begin
                    if (stage_q == CNT_W'(i) && amt_q[i]) begin
                        if (i >= 31 || (32'd1 << i) >= 32'(WIDTH)) begin
                            ovf_d  = ovf_q | (|data_q);
                            data_d = '0;
                        end else begin
                            ovf_d  = ovf_q | (|(data_q >> (32'(WIDTH) - (32'd1 << i))));
                            data_d = data_q << (32'd1 << i);
                        end
                    end
                end
                stage_d = stage_q + CNT_W'(1);
                if (stage_q == LAST_STAGE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_shift_l_nbit_seq.sv
// Randomized self-checking bench for shift_l_nbit_seq against an arithmetic reference model.
module tb_shift_l_nbit_seq;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [SW-1:0] B = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Y;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    shift_l_nbit_seq #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input int b);
        logic [63:0] wide;
        wide = {32'd0, a} << b;
        return wide[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input int b);
        logic [63:0] wide;
        if (b == 0) return 1'b0;
        wide = {32'd0, a} >> (W - b);
        return wide != 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; noise drives garbage inputs while busy/done to prove they are ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [SW-1:0] b,
                         input int stall, input bit noise, input bit full_checks);
        int n;
        logic [W-1:0] ey;
        logic         eo;
        ey = ref_y(a, int'(b));
        eo = ref_ovf(a, int'(b));
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        A = a;
        B = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (full_checks) check("accepted", {63'd0, in_ready}, 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (noise) begin
                A = $urandom;
                B = SW'($urandom);
                in_valid = 1'($urandom);
                out_ready = 1'($urandom);
            end
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("latency", 64'(n), 64'(SW));
        check("y", {32'd0, Y}, {32'd0, ey});
        check("ovf", {63'd0, ovf}, {63'd0, eo});
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                A = $urandom;
                B = SW'($urandom);
                in_valid = 1'b1;
            end
            tick();
            if (full_checks) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_ready", {63'd0, in_ready}, 64'd0);
            end
            check("stall_y", {32'd0, Y}, {32'd0, ey});
            check("stall_ovf", {63'd0, ovf}, {63'd0, eo});
        end
        out_ready = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        #1;
        out_ready = 1'b0;
        check("release_valid", {63'd0, out_valid}, 64'd0);
        check("release_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", {32'd0, Y}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        do_op(32'h0000_0001, 5'd31, 0, 1'b0, 1'b1);
        do_op(32'hF000_000F, 5'd4, 0, 1'b0, 1'b1);
        do_op(32'h0FFF_FFFF, 5'd4, 0, 1'b0, 1'b1);
        do_op(32'h1234_5678, 5'd0, 0, 1'b0, 1'b1);
        do_op(32'hFFFF_FFFF, 5'd31, 0, 1'b0, 1'b1);
        do_op(32'hDEAD_BEEF, 5'd16, 10, 1'b1, 1'b1);

        // Abort mid-operation with reset.
        A = 32'hFFFF_FFFF;
        B = 5'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_y", {32'd0, Y}, 64'd0);
        check("abort_ovf", {63'd0, ovf}, 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < SW + 2; k++) begin
            tick();
            check("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        do_op(32'h0000_0003, 5'd1, 0, 1'b0, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            do_op($urandom, SW'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
